// File: rtl/brpred_pkg.sv
// Shared types and the 2-bit saturating counter rule for the branch prediction PHT scheduler.
package brpred_pkg;

    localparam int unsigned BRPRED_IDX_W = 5;

    typedef logic [1:0] ctr2_t;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StUpdWr
    } sched_state_e;

    typedef struct packed {
        logic [BRPRED_IDX_W-1:0] idx;
        logic                    taken;
    } upd_entry_t;

    function automatic ctr2_t sat_ctr_upd(ctr2_t ctr, logic taken);
        ctr2_t nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/brpred_upd_fifo.sv
// Update queue for resolved branches: power-of-two depth, wrapping pointers, occupancy count.
module brpred_upd_fifo
    import brpred_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = upd_entry_t
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  entry_t                  push_data,
    input  logic                    pop,
    output entry_t                  head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];
    assign cnt     = cnt_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/brnch_pred_tbl_upd_sched.sv
// PHT port scheduler: init sweep, lookup/update arbitration and counter read-modify-write.
// Optional perf counters are enabled by defining BRPRED_PERF_CNT_EN.
module brnch_pred_tbl_upd_sched
    import brpred_pkg::*;
#(
    parameter int unsigned IDX_W          = BRPRED_IDX_W,
    parameter int unsigned UPD_FIFO_DEPTH = 4,
    parameter ctr2_t       INIT_CTR       = 2'b01,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              lk_valid,
    input  logic [IDX_W-1:0]                  lk_idx,
    output logic                              lk_ready,
    output logic                              lk_pred_valid,
    output logic                              lk_pred,
    output logic                              stall_fetch,
    input  logic                              upd_valid,
    input  logic [IDX_W-1:0]                  upd_idx,
    input  logic                              upd_taken,
    output logic                              upd_ready,
    output logic [IDX_W-1:0]                  tbl_addr,
    output logic                              tbl_we,
    output logic [1:0]                        tbl_wdata,
    input  logic [1:0]                        tbl_rdata,
    output logic                              init_done,
    output logic [$clog2(UPD_FIFO_DEPTH):0]   upd_cnt
`ifdef BRPRED_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                  perf_lookups,
    output logic [CNT_W-1:0]                  perf_updates,
    output logic [CNT_W-1:0]                  perf_stall_cyc
`endif
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } entry_t;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    sched_state_e     state_q;
    logic [IDX_W-1:0] sweep_ptr_q;
    logic             pred_valid_q;
    logic             init_done_q;

    entry_t push_data;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;
    logic   lk_accept;
    logic   issue_upd;

    assign upd_ready   = ~fifo_full & init_done_q;
    assign fifo_push   = upd_valid & upd_ready;
    assign push_data   = '{idx: upd_idx, taken: upd_taken};
    assign fifo_pop    = (state_q == StUpdWr);

    assign lk_ready    = (state_q == StIdle) & ~fifo_full;
    assign lk_accept   = lk_valid & lk_ready;
    assign stall_fetch = lk_valid & ~lk_ready;

    // Full queue forces a drain; otherwise lookups win and updates use idle slots.
    assign issue_upd   = (state_q == StIdle) & (fifo_full | (~lk_valid & ~fifo_empty));

    assign lk_pred_valid = pred_valid_q;
    assign lk_pred       = pred_valid_q & tbl_rdata[1];
    assign init_done     = init_done_q;

    brpred_upd_fifo #(
        .DEPTH   (UPD_FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_upd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .cnt       (upd_cnt)
    );

    // Writes are gated by rst so an asserted reset never corrupts the table.
    always_comb begin
        tbl_addr  = lk_idx;
        tbl_we    = 1'b0;
        tbl_wdata = INIT_CTR;
        unique case (state_q)
            StInit: begin
                tbl_we   = ~rst;
                tbl_addr = sweep_ptr_q;
            end
            StIdle: begin
                if (issue_upd) begin
                    tbl_addr = head.idx;
                end
            end
            StUpdWr: begin
                tbl_we    = ~rst;
                tbl_addr  = head.idx;
                tbl_wdata = sat_ctr_upd(tbl_rdata, head.taken);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StInit;
            sweep_ptr_q  <= '0;
            pred_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            pred_valid_q <= lk_accept;
            unique case (state_q)
                StInit: begin
                    sweep_ptr_q <= sweep_ptr_q + 1'b1;
                    if (sweep_ptr_q == LAST_IDX) begin
                        state_q     <= StIdle;
                        init_done_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (issue_upd) begin
                        state_q <= StUpdWr;
                    end
                end
                StUpdWr: state_q <= StIdle;
                default: state_q <= StInit;
            endcase
        end
    end

`ifdef BRPRED_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lookups   <= '0;
            perf_updates   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (lk_accept && (perf_lookups != '1)) begin
                perf_lookups <= perf_lookups + 1'b1;
            end
            if (fifo_pop && (perf_updates != '1)) begin
                perf_updates <= perf_updates + 1'b1;
            end
            if (stall_fetch && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_brnch_pred_tbl_upd_sched.sv
// Directed bench for the PHT scheduler with a behavioural 1-cycle-latency table model.
module tb_brnch_pred_tbl_upd_sched;

    logic       clk;
    logic       rst;
    logic       lk_valid;
    logic [4:0] lk_idx;
    logic       lk_ready;
    logic       lk_pred_valid;
    logic       lk_pred;
    logic       stall_fetch;
    logic       upd_valid;
    logic [4:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic [4:0] tbl_addr;
    logic       tbl_we;
    logic [1:0] tbl_wdata;
    logic [1:0] tbl_rdata;
    logic       init_done;
    logic [2:0] upd_cnt;
`ifdef BRPRED_PERF_CNT_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_updates;
    logic [31:0] perf_stall_cyc;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [1:0] pht [32];

    brnch_pred_tbl_upd_sched dut (
        .clk           (clk),
        .rst           (rst),
        .lk_valid      (lk_valid),
        .lk_idx        (lk_idx),
        .lk_ready      (lk_ready),
        .lk_pred_valid (lk_pred_valid),
        .lk_pred       (lk_pred),
        .stall_fetch   (stall_fetch),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_ready     (upd_ready),
        .tbl_addr      (tbl_addr),
        .tbl_we        (tbl_we),
        .tbl_wdata     (tbl_wdata),
        .tbl_rdata     (tbl_rdata),
        .init_done     (init_done),
        .upd_cnt       (upd_cnt)
`ifdef BRPRED_PERF_CNT_EN
        ,
        .perf_lookups  (perf_lookups),
        .perf_updates  (perf_updates),
        .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port table with synchronous read.
    always @(posedge clk) begin
        if (tbl_we) pht[tbl_addr] <= tbl_wdata;
        tbl_rdata <= pht[tbl_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_upd(input logic [4:0] idx, input logic taken);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
    endtask

    initial begin
        rst = 1'b1; lk_valid = 1'b0; lk_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        tick(); tick();
        #2;
        chk("rst_tbl_we", tbl_we, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_pred_valid", lk_pred_valid, 0);
        chk("rst_pred", lk_pred, 0);
        chk("rst_upd_cnt", upd_cnt, 0);
        chk("rst_lk_ready", lk_ready, 0);
        chk("rst_upd_ready", upd_ready, 0);

        // Init sweep: 32 writes of 01, then init_done on the 33rd cycle.
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #2;
            chk("init_sweep", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'(i), 2'b01});
            chk("init_busy", {init_done, lk_ready, upd_ready}, 3'b000);
            tick();
        end
        #2;
        chk("init_done", init_done, 1);
        chk("idle_we", tbl_we, 0);
        chk("idle_upd_ready", upd_ready, 1);

        // Lookup idx 7: weakly not-taken.
        tick(); lk_valid = 1'b1; lk_idx = 5'd7;
        #2;
        chk("lk7_ready", lk_ready, 1);
        chk("lk7_addr", tbl_addr, 7);
        tick(); lk_valid = 1'b0;
        #2;
        chk("lk7_pred_valid", lk_pred_valid, 1);
        chk("lk7_pred", lk_pred, 0);

        // Two taken updates to idx 7: 01 -> 10 -> 11.
        tick(); push_upd(5'd7, 1'b1);
        #2;
        chk("u7_ready", upd_ready, 1);
        tick();
        #2;
        chk("u7_cnt1", upd_cnt, 1);
        chk("u7_issue_addr", tbl_addr, 7);
        chk("u7_issue_we", tbl_we, 0);
        tick(); upd_valid = 1'b0;
        #2;
        chk("u7_wr1", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd7, 2'b10});
        chk("u7_wr1_cnt", upd_cnt, 2);
        chk("u7_wr1_lk_ready", lk_ready, 0);
        tick();
        #2;
        chk("u7_pop_cnt", upd_cnt, 1);
        chk("u7_idle_we", tbl_we, 0);
        tick();
        #2;
        chk("u7_wr2", {tbl_we, tbl_wdata}, {1'b1, 2'b11});
        tick(); lk_valid = 1'b1; lk_idx = 5'd7;
        #2;
        chk("lk7b_ready", lk_ready, 1);
        tick(); lk_valid = 1'b0;
        #2;
        chk("lk7b_pred", {lk_pred_valid, lk_pred}, 2'b11);

        // Third taken update saturates at 11.
        tick(); push_upd(5'd7, 1'b1);
        tick(); upd_valid = 1'b0;
        tick();
        #2;
        chk("u7_sat", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd7, 2'b11});
        tick();

        // Fill the queue while a lookup is held: (3,nt) (3,nt) (9,t) (3,t).
        lk_valid = 1'b1; lk_idx = 5'd5; push_upd(5'd3, 1'b0);
        #2;
        chk("fill_lk_ready", lk_ready, 1);
        chk("fill_upd_ready", upd_ready, 1);
        tick(); push_upd(5'd3, 1'b0);
        tick(); push_upd(5'd9, 1'b1);
        tick(); push_upd(5'd3, 1'b1);
        #2;
        chk("fill_cnt3", upd_cnt, 3);
        chk("fill_lk_prio", lk_ready, 1);
        tick(); push_upd(5'd9, 1'b0);
        #2;
        chk("full_cnt", upd_cnt, 4);
        chk("full_upd_ready", upd_ready, 0);
        chk("full_lk_ready", lk_ready, 0);
        chk("full_stall", stall_fetch, 1);
        chk("full_drain_addr", {tbl_we, tbl_addr}, {1'b0, 5'd3});
        tick();
        #2;
        chk("drain_stall", stall_fetch, 1);
        chk("drain_upd_ready", upd_ready, 0);
        chk("drain_wr_e0", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd3, 2'b00});
        tick(); lk_valid = 1'b0; upd_valid = 1'b0;
        #2;
        chk("refused_cnt", upd_cnt, 3);
        chk("unstall", stall_fetch, 0);
        chk("issue_e1", tbl_addr, 3);
        tick();
        #2;
        chk("wr_e1", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd3, 2'b00});
        tick();
        #2;
        chk("issue_e2", {upd_cnt, tbl_addr}, {3'd2, 5'd9});
        tick(); push_upd(5'd9, 1'b1);
        #2;
        chk("wr_e2", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd9, 2'b10});
        chk("wr_e2_upd_ready", upd_ready, 1);
        tick(); upd_valid = 1'b0;
        #2;
        chk("pushpop_cnt", upd_cnt, 2);
        chk("issue_e3", tbl_addr, 3);
        tick();
        #2;
        chk("wr_e3", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd3, 2'b01});
        tick();
        #2;
        chk("issue_e5", tbl_addr, 9);
        tick();
        #2;
        chk("wr_e5", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd9, 2'b11});
        tick(); lk_valid = 1'b1; lk_idx = 5'd9;
        #2;
        chk("empty_cnt", upd_cnt, 0);
        tick(); lk_idx = 5'd3;
        #2;
        chk("lk9_pred", {lk_pred_valid, lk_pred}, 2'b11);
        tick(); lk_valid = 1'b0;
        #2;
        chk("lk3_pred", {lk_pred_valid, lk_pred}, 2'b10);

        // Reset in the middle of an update write.
        tick(); push_upd(5'd12, 1'b1);
        tick(); upd_valid = 1'b0;
        tick();
        #2;
        chk("pre_rst_updwr", {tbl_we, tbl_addr}, {1'b1, 5'd12});
        rst = 1'b1;
        #1;
        chk("midrst_we", tbl_we, 0);
        chk("midrst_cnt", upd_cnt, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_pred_valid", lk_pred_valid, 0);
        tick(); rst = 1'b0;
        #2;
        chk("resweep_0", {tbl_we, tbl_addr, tbl_wdata}, {1'b1, 5'd0, 2'b01});
        tick();
        #2;
        chk("resweep_1", {tbl_we, tbl_addr}, {1'b1, 5'd1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
